// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle RV32I-subset core.
// Optional macro ILLEGAL_TRAP_EN: makes ILLEGAL a terminal trap state with a sticky illegal flag.
module multicycle_control_fsm #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          op,
    input  logic [2:0]          funct3,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                AdrSrc,
    output logic                MemWrite,
    output logic                MemReq,
    output logic                IRWrite,
    output logic [1:0]          ResultSrc,
    output logic [1:0]          ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ALUOp,
    output logic [1:0]          ImmSrc,
    output logic                RegWrite,
    output logic [RETIRE_W-1:0] retired,
    output logic                illegal
);
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWRITE, S_MEMWB,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL, S_ILLEGAL
    } state_t;

    state_t r_state, w_next;
    logic [RETIRE_W-1:0] r_retired;
    logic w_pcupdate, w_branch, w_irwrite, w_memwrite, w_memreq, w_regwrite;
    logic w_retire, w_legal;

    always_comb begin
        w_legal = 1'b0;
        case (op)
            OP_LW, OP_SW, OP_R, OP_JAL: w_legal = 1'b1;
            OP_I:   w_legal = (funct3 == 3'b000) || (funct3 == 3'b010) || (funct3[2:1] == 2'b11);
            OP_BEQ: w_legal = (funct3 == 3'b000);
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_pcupdate = 1'b0;
        w_branch   = 1'b0;
        w_irwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_memreq   = 1'b0;
        w_regwrite = 1'b0;
        w_retire   = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_memreq   = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                w_irwrite  = mem_ready;
                w_pcupdate = mem_ready;
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                if (!w_legal)                          w_next = S_ILLEGAL;
                else if (op == OP_LW || op == OP_SW)   w_next = S_MEMADR;
                else if (op == OP_R)                   w_next = S_EXECUTER;
                else if (op == OP_I)                   w_next = S_EXECUTEI;
                else if (op == OP_BEQ)                 w_next = S_BEQ;
                else                                   w_next = S_JAL;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_next  = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_memreq = 1'b1;
                AdrSrc   = 1'b1;
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWRITE: begin
                // Strobe stays up for every stalled cycle; memory samples it when ready.
                w_memreq   = 1'b1;
                w_memwrite = 1'b1;
                AdrSrc     = 1'b1;
                if (mem_ready) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
                w_retire   = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                w_next  = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
                w_retire   = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA  = 2'b10;
                ALUOp    = 2'b01;
                w_branch = 1'b1;
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_JAL: begin
                // PC <- target computed in DECODE; ALU forms the link value OldPC+4.
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                w_pcupdate = 1'b1;
                w_next     = S_ALUWB;
            end
            S_ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
                w_next = S_ILLEGAL;
`else
                w_next = S_FETCH;
`endif
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Strobes are forced low while reset is held so nothing is written during abort.
    assign PCWrite  = !reset && (w_pcupdate || (w_branch && zero));
    assign IRWrite  = !reset && w_irwrite;
    assign MemWrite = !reset && w_memwrite;
    assign MemReq   = !reset && w_memreq;
    assign RegWrite = !reset && w_regwrite;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         r_retired <= '0;
        else if (w_retire) r_retired <= r_retired + RETIRE_W'(1);
    end
    assign retired = r_retired;

`ifdef ILLEGAL_TRAP_EN
    logic r_illegal;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                          r_illegal <= 1'b0;
        else if (r_state == S_DECODE && w_next == S_ILLEGAL) r_illegal <= 1'b1;
    end
    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle control vector checks against hand-written state signatures.
module tb_multicycle_control_fsm;
    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        zero;
    logic        mem_ready;
    logic        PCWrite, AdrSrc, MemWrite, MemReq, IRWrite, RegWrite, illegal;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic [31:0] retired;
    logic [15:0] ctl;
    int          n_tests = 0;
    int          n_fail  = 0;

    multicycle_control_fsm #(.RETIRE_W(32)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .MemReq(MemReq), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc),
        .RegWrite(RegWrite), .retired(retired), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign ctl = {PCWrite, AdrSrc, MemWrite, MemReq, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, RegWrite};

    // {PCWrite,AdrSrc,MemWrite,MemReq,IRWrite, ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ImmSrc, RegWrite}
    function automatic logic [15:0] v(logic pcw, logic adr, logic mw, logic mr, logic irw,
                                      logic [1:0] rs, logic [1:0] sa, logic [1:0] sb,
                                      logic [1:0] aop, logic [1:0] imm, logic rw);
        return {pcw, adr, mw, mr, irw, rs, sa, sb, aop, imm, rw};
    endfunction
    function automatic logic [15:0] RST(logic [1:0] i); return v(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,i,0); endfunction
    function automatic logic [15:0] F(logic r, logic [1:0] i); return v(r,0,0,1,r,2'b10,2'b00,2'b10,2'b00,i,0); endfunction
    function automatic logic [15:0] D(logic [1:0] i);   return v(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,i,0); endfunction
    function automatic logic [15:0] MA(logic [1:0] i);  return v(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,i,0); endfunction
    function automatic logic [15:0] MR(logic [1:0] i);  return v(0,1,0,1,0,2'b00,2'b00,2'b00,2'b00,i,0); endfunction
    function automatic logic [15:0] MW(logic [1:0] i);  return v(0,1,1,1,0,2'b00,2'b00,2'b00,2'b00,i,0); endfunction
    function automatic logic [15:0] MWB(logic [1:0] i); return v(0,0,0,0,0,2'b01,2'b00,2'b00,2'b00,i,1); endfunction
    function automatic logic [15:0] ER(logic [1:0] i);  return v(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,i,0); endfunction
    function automatic logic [15:0] EI(logic [1:0] i);  return v(0,0,0,0,0,2'b00,2'b10,2'b01,2'b10,i,0); endfunction
    function automatic logic [15:0] AWB(logic [1:0] i); return v(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,i,1); endfunction
    function automatic logic [15:0] BQ(logic z);        return v(z,0,0,0,0,2'b00,2'b10,2'b00,2'b01,2'b10,0); endfunction
    function automatic logic [15:0] JL();               return v(1,0,0,0,0,2'b00,2'b01,2'b10,2'b00,2'b11,0); endfunction
    function automatic logic [15:0] ILL(logic [1:0] i); return v(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,i,0); endfunction

    task automatic chk16(string tag, logic [15:0] o, logic [15:0] e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic chk32(string tag, logic [31:0] o, logic [31:0] e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, e);
        end
    endtask

    // Check the control vector just after a falling edge, then advance one clock.
    task automatic cyc(string tag, logic [15:0] e);
        #1;
        chk16(tag, ctl, e);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; op = 7'b0000011; funct3 = 3'b010; zero = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        cyc("reset_ctl", RST(2'b00));
        chk32("reset_retired", retired, 0);
        chk16("reset_illegal", {15'd0, illegal}, 16'd0);
        reset = 1'b0;

        // lw: 5 cycles, RegWrite only in MEMWB; mem_ready low in DECODE must be ignored
        cyc("lw_fetch", F(1, 2'b00));
        mem_ready = 1'b0;
        cyc("lw_decode", D(2'b00));
        mem_ready = 1'b1;
        cyc("lw_memadr", MA(2'b00));
        cyc("lw_memread", MR(2'b00));
        chk32("lw_retired_before", retired, 0);
        cyc("lw_memwb", MWB(2'b00));
        chk32("lw_retired_after", retired, 1);

        // reset pulsed mid-MEMADR aborts and clears retired
        cyc("rst_fetch", F(1, 2'b00));
        cyc("rst_decode", D(2'b00));
        #1 chk16("rst_memadr", ctl, MA(2'b00));
        #1 reset = 1'b1;
        #1 chk16("rst_async_ctl", ctl, RST(2'b00));
        chk32("rst_async_retired", retired, 0);
        @(negedge clk);
        cyc("rst_hold_ctl", RST(2'b00));
        reset = 1'b0;

        // sw with 3 stall cycles in MEMWRITE: 7 cycles, MemWrite for 4
        op = 7'b0100011;
        cyc("sw_fetch", F(1, 2'b01));
        cyc("sw_decode", D(2'b01));
        cyc("sw_memadr", MA(2'b01));
        mem_ready = 1'b0;
        cyc("sw_memwrite_s1", MW(2'b01));
        cyc("sw_memwrite_s2", MW(2'b01));
        cyc("sw_memwrite_s3", MW(2'b01));
        chk32("sw_retired_stalled", retired, 0);
        mem_ready = 1'b1;
        cyc("sw_memwrite_go", MW(2'b01));
        chk32("sw_retired", retired, 1);

        // beq taken then not taken
        op = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
        cyc("beq1_fetch", F(1, 2'b10));
        cyc("beq1_decode", D(2'b10));
        cyc("beq1_beq", BQ(1'b1));
        chk32("beq1_retired", retired, 2);
        zero = 1'b0;
        cyc("beq0_fetch", F(1, 2'b10));
        cyc("beq0_decode", D(2'b10));
        cyc("beq0_beq", BQ(1'b0));
        chk32("beq0_retired", retired, 3);

        // R-type with one fetch stall
        op = 7'b0110011; funct3 = 3'b000; mem_ready = 1'b0;
        cyc("r_fetch_stall", F(0, 2'b00));
        mem_ready = 1'b1;
        cyc("r_fetch", F(1, 2'b00));
        cyc("r_decode", D(2'b00));
        cyc("r_exec", ER(2'b00));
        cyc("r_aluwb", AWB(2'b00));
        chk32("r_retired", retired, 4);

        // I-type slti (funct3=010)
        op = 7'b0010011; funct3 = 3'b010;
        cyc("i_fetch", F(1, 2'b00));
        cyc("i_decode", D(2'b00));
        cyc("i_exec", EI(2'b00));
        cyc("i_aluwb", AWB(2'b00));
        chk32("i_retired", retired, 5);

        // jal, mem_ready low outside fetch is ignored
        op = 7'b1101111; funct3 = 3'b000;
        cyc("jal_fetch", F(1, 2'b11));
        mem_ready = 1'b0;
        cyc("jal_decode", D(2'b11));
        chk32("jal_retired_mid", retired, 5);
        cyc("jal_jal", JL());
        cyc("jal_aluwb", AWB(2'b11));
        chk32("jal_retired", retired, 6);
        mem_ready = 1'b1;

        // illegal I-type funct3=001, then unknown opcode 1111111
        op = 7'b0010011; funct3 = 3'b001;
        cyc("ill_i_fetch", F(1, 2'b00));
        cyc("ill_i_decode", D(2'b00));
`ifdef ILLEGAL_TRAP_EN
        chk16("ill_i_flag", {15'd0, illegal}, 16'd1);
        cyc("ill_i_stuck1", ILL(2'b00));
        cyc("ill_i_stuck2", ILL(2'b00));
        chk16("ill_i_flag_held", {15'd0, illegal}, 16'd1);
        chk32("ill_i_retired", retired, 6);
        reset = 1'b1;
        #1 chk16("ill_i_flag_clr", {15'd0, illegal}, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        op = 7'b1111111; funct3 = 3'b000;
        cyc("ill_op_fetch", F(1, 2'b00));
        cyc("ill_op_decode", D(2'b00));
        chk16("ill_op_flag", {15'd0, illegal}, 16'd1);
        cyc("ill_op_stuck1", ILL(2'b00));
        cyc("ill_op_stuck2", ILL(2'b00));
        cyc("ill_op_stuck3", ILL(2'b00));
        chk32("ill_op_retired", retired, 0);
`else
        chk16("ill_i_flag", {15'd0, illegal}, 16'd0);
        cyc("ill_i_nop", ILL(2'b00));
        chk32("ill_i_retired", retired, 6);
        op = 7'b1111111; funct3 = 3'b000;
        cyc("ill_op_fetch", F(1, 2'b00));
        cyc("ill_op_decode", D(2'b00));
        cyc("ill_op_nop", ILL(2'b00));
        chk16("ill_op_flag", {15'd0, illegal}, 16'd0);
        chk32("ill_op_retired", retired, 6);
        cyc("ill_op_refetch", F(1, 2'b00));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
